// File: rtl/gf180mcu_osu_sc_9t_clkdiv_gen.sv
// Glitch-free programmable clock divider: divisor and run/stop changes take effect only at period boundaries.
// Optional macro CLKDIV_GEN_COMP_OUT_EN builds a registered anti-phase output YN (tied 0 otherwise).
module gf180mcu_osu_sc_9t_clkdiv_gen #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  output logic             Y,
  output logic             YN,
  output logic             ACK,
  output logic             TICK
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;
  localparam logic [WIDTH-1:0] DEF_P = (DEFAULT_DIV < 2) ? WIDTH'(2) : WIDTH'(DEFAULT_DIV);

  // Divisors are stored already clamped to a period of at least 2.
  function automatic logic [WIDTH-1:0] clamp_p(input logic [WIDTH-1:0] d);
    return (d < WIDTH'(2)) ? WIDTH'(2) : d;
  endfunction

  function automatic logic [WIDTH-1:0] high_of(input logic [WIDTH-1:0] p);
    logic [WIDTH:0] t;
    t = {1'b0, p} + (WIDTH+1)'(1);
    return t[WIDTH:1];
  endfunction

  logic [0:0]       st_q, st_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             y_q, y_d, ack_q, ack_d, tick_q, tick_d;
  logic [WIDTH-1:0] new_per;
  logic             have_new;

  assign new_per  = LOAD ? clamp_p(DIV) : pdiv_q;
  assign have_new = LOAD | pend_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    per_d  = per_q;
    pdiv_d = pdiv_q;
    pend_d = pend_q;
    y_d    = 1'b0;
    ack_d  = 1'b0;
    tick_d = 1'b0;
    case (st_q)
      S_IDLE: begin
        cnt_d = '0;
        if (have_new) begin
          per_d  = new_per;
          pend_d = 1'b0;
          ack_d  = 1'b1;
        end
        if (EN) begin
          st_d   = S_RUN;
          y_d    = 1'b1;
          tick_d = 1'b1;
        end
      end
      S_RUN: begin
        if (cnt_q == per_q - WIDTH'(1)) begin
          cnt_d = '0;
          if (!EN) begin
            // Stopping: a boundary-cycle load is kept and applied from IDLE.
            st_d = S_IDLE;
            if (LOAD) begin
              pend_d = 1'b1;
              pdiv_d = clamp_p(DIV);
            end
          end else begin
            y_d    = 1'b1;
            tick_d = 1'b1;
            if (have_new) begin
              per_d  = new_per;
              pend_d = 1'b0;
              ack_d  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
          y_d   = (cnt_d < high_of(per_q));
          if (LOAD) begin
            pend_d = 1'b1;
            pdiv_d = clamp_p(DIV);
          end
        end
      end
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q   <= S_IDLE;
      cnt_q  <= '0;
      per_q  <= DEF_P;
      pdiv_q <= DEF_P;
      pend_q <= 1'b0;
      y_q    <= 1'b0;
      ack_q  <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      per_q  <= per_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      y_q    <= y_d;
      ack_q  <= ack_d;
      tick_q <= tick_d;
    end
  end

  assign Y    = y_q;
  assign ACK  = ack_q;
  assign TICK = tick_q;

`ifdef CLKDIV_GEN_COMP_OUT_EN
  logic yn_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) yn_q <= 1'b1;
    else     yn_q <= ~y_d;
  end
  assign YN = yn_q;
`else
  assign YN = 1'b0;
`endif

endmodule

// File: tb/tb_gf180mcu_osu_sc_9t_clkdiv_gen.sv
// Directed bench for the clock divider: period/duty, load timing, stop/restart and async reset.
module tb_gf180mcu_osu_sc_9t_clkdiv_gen;
  localparam int WIDTH = 8;

  logic             CLK = 1'b0;
  logic             RST, EN, LOAD;
  logic [WIDTH-1:0] DIV;
  logic             Y, YN, ACK, TICK;
  int               n_chk = 0;
  int               n_err = 0;

  gf180mcu_osu_sc_9t_clkdiv_gen #(.WIDTH(WIDTH), .DEFAULT_DIV(4)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .DIV(DIV), .LOAD(LOAD),
    .Y(Y), .YN(YN), .ACK(ACK), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic yn_exp(input logic y);
`ifdef CLKDIV_GEN_COMP_OUT_EN
    return ~y;
`else
    return 1'b0;
`endif
  endfunction

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // n cycles of a steady period p with h high cycles, starting at phase ph; no ACK expected.
  task automatic run_per(input string tag, input int n, input int p, input int h, input int ph);
    logic ey;
    for (int k = 0; k < n; k++) begin
      step();
      ey = (((ph + k) % p) < h);
      chk({tag, "_y"},    Y,    ey);
      chk({tag, "_tick"}, TICK, ((ph + k) % p) == 0);
      chk({tag, "_ack"},  ACK,  1'b0);
      chk({tag, "_yn"},   YN,   yn_exp(ey));
    end
  endtask

  task automatic chk_bnd(input string tag);
    chk({tag, "_ack"},  ACK,  1'b1);
    chk({tag, "_y"},    Y,    1'b1);
    chk({tag, "_tick"}, TICK, 1'b1);
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; LOAD = 1'b0; DIV = '0;
    #12;
    chk("rst_y", Y, 1'b0);
    chk("rst_ack", ACK, 1'b0);
    chk("rst_tick", TICK, 1'b0);
    chk("rst_yn", YN, yn_exp(1'b0));
    RST = 1'b0;
    step(); chk("idle_y0", Y, 1'b0);
    step(); chk("idle_y1", Y, 1'b0);

    // Default divisor 4: 2 high / 2 low
    EN = 1'b1;
    run_per("def", 8, 4, 2, 0);

    // Stop at the boundary, then load 5 in IDLE
    EN = 1'b0;
    step(); chk("stop_y", Y, 1'b0); chk("stop_tick", TICK, 1'b0);
    LOAD = 1'b1; DIV = 8'd5;
    step(); chk("idle_ld_ack", ACK, 1'b1); chk("idle_ld_y", Y, 1'b0);
    LOAD = 1'b0;
    step(); chk("idle_ack_clr", ACK, 1'b0);
    EN = 1'b1;
    run_per("p5", 50, 5, 3, 0);

    // Boundary-cycle load of 4 applies to the very next period
    LOAD = 1'b1; DIV = 8'd4;
    step(); chk_bnd("bnd4");
    LOAD = 1'b0;
    step(); chk("p4_c1_y", Y, 1'b1); chk("p4_c1_ack", ACK, 1'b0);
    LOAD = 1'b1; DIV = 8'd7;
    step(); chk("p4_c2_y", Y, 1'b0); chk("p4_c2_ack", ACK, 1'b0);
    DIV = 8'd3;
    step(); chk("p4_c3_y", Y, 1'b0); chk("p4_c3_ack", ACK, 1'b0);
    LOAD = 1'b0;
    step(); chk_bnd("bnd3");
    run_per("p3", 8, 3, 2, 1);

    // DIV 0 and 1 both clamp to period 2
    LOAD = 1'b1; DIV = 8'd0;
    step(); chk_bnd("bnd0");
    LOAD = 1'b0;
    run_per("p2a", 5, 2, 1, 1);
    LOAD = 1'b1; DIV = 8'd1;
    step(); chk_bnd("bnd1");
    LOAD = 1'b0;
    run_per("p2b", 5, 2, 1, 1);

    // P=6, EN dropped at cnt=0: period completes then parks low
    LOAD = 1'b1; DIV = 8'd6;
    step(); chk_bnd("bnd6");
    LOAD = 1'b0; EN = 1'b0;
    run_per("p6", 5, 6, 3, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("park_y", Y, 1'b0);
      chk("park_tick", TICK, 1'b0);
    end
    EN = 1'b1;
    run_per("reen", 1, 6, 3, 0);

    // Async reset mid-high with a divisor pending
    LOAD = 1'b1; DIV = 8'd9;
    step(); chk("pend_y", Y, 1'b1);
    LOAD = 1'b0;
    #2 RST = 1'b1;
    #1;
    chk("arst_y", Y, 1'b0);
    chk("arst_ack", ACK, 1'b0);
    chk("arst_tick", TICK, 1'b0);
    chk("arst_yn", YN, yn_exp(1'b0));
    step(); step();
    RST = 1'b0;
    run_per("post_rst", 12, 4, 2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
